riptide_banked_mem: RTL and testbench

- Parametrised banked scratchpad for the RipTide fabric: NUM_PORTS fabric memory-PE request ports share NUM_BANKS single-ported SRAM banks.
- Word-interleaved address mapping; per-bank round-robin arbitration; fixed 1-cycle response.
- Generalises the fixed 8x32KB main memory into a configurable, contention-aware block instantiated beside the fabric.

---
 rtl/riptide_banked_mem.sv | 200 ++++++++++++++++++++
 tb/tb_riptide_banked_mem.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/riptide_banked_mem.sv
// riptide_banked_mem -- banked scratchpad shared by the RipTide fabric
// memory PEs.
//
// NUM_PORTS request ports share NUM_BANKS single-ported SRAM banks. Words are
// interleaved across banks. Each bank runs its own round-robin arbiter and
// grants at most one port per cycle. Every grant gets a registered response in
// the following cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-port handshake; ready is combinational, one winner
//                     per bank, forced low while rst_n=0
//   req_we            1 = write, 0 = read
//   req_addr          byte addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata         write data, packed like req_addr
//   resp_valid        high exactly one cycle after a handshake
//   resp_we           echoes req_we of the completed request
//   resp_rdata        read data, 0 for writes
//
// Optional feature, enabled by defining RIPTIDE_BANKED_MEM_STATS_EN:
//   stats_clr         synchronous clear of the stall counters (wins over incr)
//   stall_cnt         per-port saturating 32-bit count of valid & !ready cycles

module riptide_banked_mem_bank #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BANK_WORDS = 8192,
   parameter int WORD_W     = 13,
   parameter int PTR_W      = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            cand,
   input  logic [NUM_PORTS-1:0]            port_we,
   input  logic [NUM_PORTS*WORD_W-1:0]     port_word,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
   output logic [NUM_PORTS-1:0]            grant,
   output logic [DATA_WIDTH-1:0]           rdata
);

   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      win;
   logic                  found;
   int                    idx;
   logic [DATA_WIDTH-1:0] mem [BANK_WORDS];

   // Search upward from rr_ptr, wrapping modulo NUM_PORTS; first candidate wins.
   always_comb begin
      grant = '0;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_PORTS;
         if (!found && cand[idx]) begin
            found      = 1'b1;
            win        = idx[PTR_W-1:0];
            grant[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (found)
         rr_ptr <= (win == PTR_W'(NUM_PORTS-1)) ? '0 : win + 1'b1;
   end

   // Plain SRAM: no reset on contents or read register. The read register is
   // only observed through the response mux, which gates it on a valid read.
   always_ff @(posedge clk) begin
      if (found) begin
         if (port_we[win])
            mem[port_word[win*WORD_W +: WORD_W]] <= port_wdata[win*DATA_WIDTH +: DATA_WIDTH];
         else
            rdata <= mem[port_word[win*WORD_W +: WORD_W]];
      end
   end

endmodule

module riptide_banked_mem #(
   parameter int NUM_PORTS  = 4,
   parameter int NUM_BANKS  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BANK_WORDS = 8192
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_ready,
   input  logic [NUM_PORTS-1:0]            req_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]            resp_valid,
   output logic [NUM_PORTS-1:0]            resp_we,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] resp_rdata
`ifdef RIPTIDE_BANKED_MEM_STATS_EN
   ,
   input  logic                            stats_clr,
   output logic [NUM_PORTS*32-1:0]         stall_cnt
`endif
);

   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int WORD_W = $clog2(BANK_WORDS);
   localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [BANK_W-1:0]           port_bank [NUM_PORTS];
   logic [NUM_PORTS*WORD_W-1:0] port_word;
   logic [NUM_PORTS-1:0]        cand  [NUM_BANKS];
   logic [NUM_PORTS-1:0]        grant [NUM_BANKS];
   logic [DATA_WIDTH-1:0]       bank_rdata [NUM_BANKS];
   logic [BANK_W-1:0]           resp_bank [NUM_PORTS];
   logic                        unused_addr;

   // Byte offset and bits above the scratchpad size are dropped, so addresses
   // wrap modulo the total capacity.
   assign unused_addr = ^req_addr;

   always_comb begin
      port_word = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_bank[p] = req_addr[p*ADDR_WIDTH+2 +: BANK_W];
         port_word[p*WORD_W +: WORD_W] = req_addr[p*ADDR_WIDTH+2+BANK_W +: WORD_W];
      end
   end

   // Gating candidates with rst_n keeps ready low and banks idle during reset.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++)
         for (int p = 0; p < NUM_PORTS; p++)
            cand[b][p] = rst_n & req_valid[p] & (port_bank[p] == BANK_W'(b));
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      riptide_banked_mem_bank #(
         .NUM_PORTS (NUM_PORTS),
         .DATA_WIDTH(DATA_WIDTH),
         .BANK_WORDS(BANK_WORDS),
         .WORD_W    (WORD_W),
         .PTR_W     (PTR_W)
      ) u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .cand      (cand[b]),
         .port_we   (req_we),
         .port_word (port_word),
         .port_wdata(req_wdata),
         .grant     (grant[b]),
         .rdata     (bank_rdata[b])
      );
   end

   // A port targets exactly one bank, so OR-ing the bank grants is one-hot safe.
   always_comb begin
      req_ready = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         req_ready = req_ready | grant[b];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= '0;
         resp_we    <= '0;
         for (int p = 0; p < NUM_PORTS; p++)
            resp_bank[p] <= '0;
      end else begin
         resp_valid <= req_valid & req_ready;
         resp_we    <= req_we & req_valid & req_ready;
         for (int p = 0; p < NUM_PORTS; p++)
            resp_bank[p] <= port_bank[p];
      end
   end

   // Read data comes straight from the bank's read register, which was loaded
   // on the same edge that raised resp_valid.
   always_comb begin
      resp_rdata = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         if (resp_valid[p] && !resp_we[p])
            resp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[resp_bank[p]];
   end

`ifdef RIPTIDE_BANKED_MEM_STATS_EN
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stall
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            stall_cnt[p*32 +: 32] <= '0;
         else if (stats_clr)
            stall_cnt[p*32 +: 32] <= '0;
         else if (req_valid[p] && !req_ready[p] && (stall_cnt[p*32 +: 32] != 32'hFFFF_FFFF))
            stall_cnt[p*32 +: 32] <= stall_cnt[p*32 +: 32] + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_riptide_banked_mem.sv
module tb_riptide_banked_mem;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NP-1:0]      req_valid = '0;
   logic [NP-1:0]      req_ready;
   logic [NP-1:0]      req_we = '0;
   logic [NP*AW-1:0]   req_addr = '0;
   logic [NP*DW-1:0]   req_wdata = '0;
   logic [NP-1:0]      resp_valid;
   logic [NP-1:0]      resp_we;
   logic [NP*DW-1:0]   resp_rdata;
`ifdef RIPTIDE_BANKED_MEM_STATS_EN
   logic               stats_clr = 1'b0;
   logic [NP*32-1:0]   stall_cnt;
`endif

   riptide_banked_mem dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_we   (resp_we),
      .resp_rdata(resp_rdata)
`ifdef RIPTIDE_BANKED_MEM_STATS_EN
      ,
      .stats_clr (stats_clr),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        we;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb [NP][$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] a_v [NP];
   logic [31:0] w_v [NP];
   logic [31:0] e_v [NP];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every presented response must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int p = 0; p < NP; p++) begin
            if (sb[p].size() != 0 && sb[p][0].due < cyc) begin
               checks++; errors++;
               $display("FAIL resp_missing port%0d: no response, required at cycle %0d", p, sb[p][0].due);
               void'(sb[p].pop_front());
            end
            if (resp_valid[p]) begin
               checks++;
               if (sb[p].size() == 0) begin
                  errors++;
                  $display("FAIL resp_spurious port%0d: got we=%0b rdata=%h, required none", p, resp_we[p], resp_rdata[p*DW +: DW]);
               end else begin
                  exp_t e;
                  e = sb[p].pop_front();
                  if (e.due != cyc || e.we !== resp_we[p] || e.rdata !== resp_rdata[p*DW +: DW]) begin
                     errors++;
                     $display("FAIL resp port%0d: got cyc=%0d we=%0b rdata=%h, required cyc=%0d we=%0b rdata=%h",
                              p, cyc, resp_we[p], resp_rdata[p*DW +: DW], e.due, e.we, e.rdata);
                  end
               end
            end
         end
      end
   end

   task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0] we);
      req_valid = v;
      req_we    = we;
      for (int p = 0; p < NP; p++) begin
         req_addr[p*AW +: AW]  = a_v[p];
         req_wdata[p*DW +: DW] = w_v[p];
      end
   endtask

   // One request cycle: check the grant vector, then book the expected responses.
   task automatic step(input string name, input logic [NP-1:0] v, input logic [NP-1:0] we,
                       input logic [NP-1:0] exp_rdy, input bit push);
      exp_t e;
      @(posedge clk); #1;
      drive(v, we);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL %s ready: got %b, required %b", name, req_ready, exp_rdy);
      end
      if (push)
         for (int p = 0; p < NP; p++)
            if (exp_rdy[p]) begin
               e.due = cyc + 1; e.we = we[p]; e.rdata = we[p] ? 32'h0 : e_v[p];
               sb[p].push_back(e);
            end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   initial begin
      // Reset state, with requests presented to prove ready is forced low.
      for (int p = 0; p < NP; p++) begin a_v[p] = 32'(p*4); w_v[p] = '0; e_v[p] = '0; end
      drive(4'b1111, 4'b0000);
      #12;
      chk("reset_ready", 64'(req_ready), 64'h0);
      chk("reset_resp_valid", 64'(resp_valid), 64'h0);
      chk("reset_resp_we", 64'(resp_we), 64'h0);
      chk("reset_resp_rdata", 64'(resp_rdata[63:0]), 64'h0);
      req_valid = '0;
      @(negedge clk); rst_n = 1'b1;

      // Single port: write then back-to-back read of the same word.
      a_v[0] = 32'h40; w_v[0] = 32'hDEADBEEF;
      step("wr40", 4'b0001, 4'b0001, 4'b0001, 1'b1);
      e_v[0] = 32'hDEADBEEF;
      step("rd40", 4'b0001, 4'b0000, 4'b0001, 1'b1);
      idle();

      // Four ports hit banks 0..3 in parallel.
      for (int p = 0; p < NP; p++) begin a_v[p] = 32'(p*4); w_v[p] = 32'hA0 + 32'(p); e_v[p] = 32'hA0 + 32'(p); end
      step("par_wr", 4'b1111, 4'b1111, 4'b1111, 1'b1);
      step("par_rd", 4'b1111, 4'b0000, 4'b1111, 1'b1);
      idle();

      // Seed 0x20 for the conflict test; bank contents survive reset.
      a_v[1] = 32'h20; w_v[1] = 32'h5A5A_0020;
      step("wr20", 4'b0010, 4'b0010, 4'b0010, 1'b1);
      idle();

      // Wrap: 0x40000 aliases 0x0 with 256KB total.
      a_v[1] = 32'h0; w_v[1] = 32'h11;
      step("wr0", 4'b0010, 4'b0010, 4'b0010, 1'b1);
      a_v[2] = 32'h40000; e_v[2] = 32'h11;
      step("rd_wrap", 4'b0100, 4'b0000, 4'b0100, 1'b1);
      idle();
      repeat (2) @(posedge clk);

      // Reset mid-op: read from port2 moves bank0's pointer to 3, then reset
      // lands just after the response edge and must drop it.
      a_v[2] = 32'h20;
      step("rd_pre_rst", 4'b0100, 4'b0000, 4'b0100, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      for (int p = 0; p < NP; p++) a_v[p] = 32'h20;
      drive(4'b1111, 4'b0000);
      #1;
      chk("rst_drop_resp_valid", 64'(resp_valid), 64'h0);
      chk("rst_ready_forced", 64'(req_ready), 64'h0);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); rst_n = 1'b1;

      // Conflict on bank 0 from a fresh pointer: p0,p1,p2,p3,p0.
      for (int p = 0; p < NP; p++) e_v[p] = 32'h5A5A_0020;
      step("rr0", 4'b1111, 4'b0000, 4'b0001, 1'b1);
      step("rr1", 4'b1111, 4'b0000, 4'b0010, 1'b1);
      step("rr2", 4'b1111, 4'b0000, 4'b0100, 1'b1);
      step("rr3", 4'b1111, 4'b0000, 4'b1000, 1'b1);
      step("rr4", 4'b1111, 4'b0000, 4'b0001, 1'b1);
      idle();

`ifdef RIPTIDE_BANKED_MEM_STATS_EN
      @(posedge clk); #1; stats_clr = 1'b1;
      @(posedge clk); #1; stats_clr = 1'b0;
      @(negedge clk);
      chk("stall_clr0", stall_cnt[63:0], 64'h0);
      // Ports 0,1 on bank 2; pointer there is 0 after reset.
      a_v[0] = 32'h8; a_v[1] = 32'h8; e_v[0] = 32'hA2; e_v[1] = 32'hA2;
      step("st0", 4'b0011, 4'b0000, 4'b0001, 1'b1);
      step("st1", 4'b0011, 4'b0000, 4'b0010, 1'b1);
      step("st2", 4'b0011, 4'b0000, 4'b0001, 1'b1);
      step("st3", 4'b0011, 4'b0000, 4'b0010, 1'b1);
      idle();
      @(negedge clk);
      chk("stall_p0", 64'(stall_cnt[31:0]), 64'd2);
      chk("stall_p1", 64'(stall_cnt[63:32]), 64'd2);
      chk("stall_sum", 64'(stall_cnt[31:0]) + 64'(stall_cnt[63:32]), 64'd4);
      @(posedge clk); #1; stats_clr = 1'b1;
      @(posedge clk); #1; stats_clr = 1'b0;
      @(negedge clk);
      chk("stall_clr1", stall_cnt[63:0], 64'h0);
`endif

      // Drain, then every booked response must have been seen.
      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int p = 0; p < NP; p++) chk($sformatf("sb_empty_p%0d", p), 64'(sb[p].size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
